// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared AES-128 constants, key-schedule FSM states and GF(2^8) helpers
// used by the key-expansion sequencer and its round-key generator.
package aes_key_schedule_ctrl_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_NUM_RKEYS  = 11;
    localparam int AES_KEY_W      = 128;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } ks_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] b;
        sq = x;
        b  = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load handshake, status and round-key read port of the key-schedule sequencer.
interface aes_key_schedule_ctrl_if;
    import aes_key_schedule_ctrl_pkg::*;

    logic [AES_KEY_W-1:0] key_in;
    logic                 key_valid;
    logic                 key_ready;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic                 keys_valid;
    logic [3:0]           rk_rd_addr;
    logic [AES_KEY_W-1:0] rk_rd_data;

    modport master (
        output key_in, key_valid, flush, rk_rd_addr,
        input  key_ready, busy, done, keys_valid, rk_rd_data
    );

    modport slave (
        input  key_in, key_valid, flush, rk_rd_addr,
        output key_ready, busy, done, keys_valid, rk_rd_data
    );

endinterface

// File: rtl/aes_key_schedule_ctrl_generate_key.sv
// Single-round AES-128 key generator: OUT_KEY is the next round key of IN_KEY,
// valid SBOX_LAT cycles after IN_KEY/ROUND_KEY become stable.
module GENERATE_KEY
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic                 CLK,
    input  logic [AES_KEY_W-1:0] IN_KEY,
    input  logic [3:0]           ROUND_KEY,
    output logic [AES_KEY_W-1:0] OUT_KEY,
    output logic [AES_KEY_W-1:0] OUT_KEY_R
);

    localparam int PIPE_W = SBOX_LAT * AES_KEY_W;

    logic [31:0]          w0, w1, w2, w3;
    logic [31:0]          temp;
    logic [AES_KEY_W-1:0] next_key;
    logic [PIPE_W-1:0]    pipe;

    always_comb begin
        w0   = IN_KEY[127:96];
        w1   = IN_KEY[95:64];
        w2   = IN_KEY[63:32];
        w3   = IN_KEY[31:0];
        // SubWord(RotWord(w3)) xor Rcon
        temp = {aes_sbox(w3[23:16]) ^ aes_rcon(ROUND_KEY), aes_sbox(w3[15:8]),
                aes_sbox(w3[7:0]), aes_sbox(w3[31:24])};
        next_key[127:96] = w0 ^ temp;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    if (SBOX_LAT == 1) begin : g_one_stage
        always_ff @(posedge CLK) pipe <= next_key;
    end else begin : g_multi_stage
        always_ff @(posedge CLK) pipe <= {pipe[PIPE_W-AES_KEY_W-1:0], next_key};
    end

    assign OUT_KEY = pipe[PIPE_W-1 -: AES_KEY_W];

    always_ff @(posedge CLK) OUT_KEY_R <= OUT_KEY;

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-expansion sequencer: steps GENERATE_KEY through rounds 0..9 and
// keeps all 11 round keys in flops behind a registered, keys_valid-gated read port.
module aes_key_schedule_ctrl
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_key_schedule_ctrl_if.slave  bus
);

    localparam logic [1:0] CNT_LAST   = 2'(SBOX_LAT - 1);
    localparam logic [3:0] LAST_ROUND = 4'(AES_NUM_ROUNDS - 1);
    localparam logic [3:0] MAX_ADDR   = 4'(AES_NUM_RKEYS - 1);

    ks_state_t            state, state_next;
    logic [AES_KEY_W-1:0] cur_key;
    logic [AES_KEY_W-1:0] gen_key;
    logic [AES_KEY_W-1:0] rk [AES_NUM_RKEYS];
    logic [3:0]           round;
    logic [1:0]           cnt;
    logic                 load, capture, finish;
    logic                 done, keys_valid;
    logic [AES_KEY_W-1:0] rd_data;

    GENERATE_KEY #(.SBOX_LAT(SBOX_LAT)) u_generate_key (
        .CLK       (clk),
        .IN_KEY    (cur_key),
        .ROUND_KEY (round),
        .OUT_KEY   (gen_key),
        .OUT_KEY_R ()
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    load       = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                if (round == LAST_ROUND) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
        // flush wins over both a key accept and a capture in the same cycle
        if (bus.flush) begin
            state_next = IDLE;
            load       = 1'b0;
            capture    = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round      <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            done <= finish;
            if (load) begin
                round <= '0;
                cnt   <= '0;
            end else if (capture) begin
                if (!finish) round <= round + 4'd1;
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 2'd1;
            end
            if (finish)                keys_valid <= 1'b1;
            else if (load || bus.flush) keys_valid <= 1'b0;
            rd_data <= (keys_valid && bus.rk_rd_addr <= MAX_ADDR) ? rk[bus.rk_rd_addr] : '0;
        end
    end

    // Key storage is deliberately unreset; keys_valid hides stale contents.
    always_ff @(posedge clk) begin
        if (load) begin
            cur_key <= bus.key_in;
            rk[0]   <= bus.key_in;
        end else if (capture) begin
            cur_key               <= gen_key;
            rk[4'(round + 4'd1)]  <= gen_key;
        end
    end

    assign bus.key_ready  = (state == IDLE) && !rst;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;
    assign bus.keys_valid = keys_valid;
    assign bus.rk_rd_data = rd_data;

endmodule
